dmem_ctrl: RTL and testbench
============================

// Module: dmem_ctrl
// PURPOSE
//  Parametrised data-memory controller for the RV32I multi-cycle core: word-organised RAM
//  with byte/half/word stores (SB/SH/SW), sign/zero-extending loads (LB/LH/LW/LBU/LHU),
//  valid/ready request and response handshakes, configurable read latency and fault
//  reporting (misaligned, out-of-range, illegal func3). Sits between the LSU FSM and storage.
// PARAMETERS
//  ADDR_W     4      word-index bits; DEPTH = 2**ADDR_W words (byte span DEPTH*4)
//  READ_LAT   1      cycles from request accept to response valid; legal 1..4
//  BASE_ADDR  32'h0  byte address of word 0; must be 4-byte aligned
// PORTS
//  clk        in   1   clock, all state updates on posedge
//  rst_n      in   1   synchronous active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   controller can accept; high only in IDLE
//  req_we     in   1   1 = store, 0 = load
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, LSBs used for SB/SH
//  req_func3  in   3   RV32I funct3 of the load/store
//  rsp_valid  out  1   response present; held until rsp_ready
//  rsp_ready  in   1   consumer accepts response
//  rsp_rdata  out  32  extended load data; 0 for stores and faults
//  rsp_err    out  1   access faulted; no memory side effect occurred
// BEHAVIOUR
//  - One clock, reset synchronous active-low: rst_n sampled low at posedge -> state IDLE,
//    req_ready=1 next cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
//    Memory array is NOT cleared. Reset mid-ACCESS drops the request; a store not yet
//    committed is never written.
//  - FSM: IDLE -> ACCESS on req_valid&&req_ready (request fields registered at that edge).
//    ACCESS holds READ_LAT cycles (down-counter loaded with READ_LAT-1), then -> RESP.
//    RESP -> IDLE on rsp_valid&&rsp_ready. No pipelining: one outstanding request.
//  - Latency: accept at edge E, rsp_valid rises at edge E+READ_LAT, identical for
//    loads, stores and faults. Earliest next accept: edge after rsp handshake.
//  - rsp_* outputs registered, stable while rsp_valid && !rsp_ready.
//  - Fault check on the registered request (priority order, first hit reported):
//    illegal func3 (load: 011/110/111; store: any >3'b010) ->
//    out-of-range (addr < BASE_ADDR or addr-BASE_ADDR >= DEPTH*4) ->
//    misaligned (half with addr[0]=1; word with addr[1:0]!=0).
//    Faulted access: rsp_err=1, rsp_rdata=0, no write.
//  - Word index = (addr-BASE_ADDR)[ADDR_W+1:2]; lane = addr[1:0].
//  - Store: commits at the first ACCESS edge as read-modify-write of one word with byte
//    enables: SB lane k -> byte k only; SH addr[1]=0 -> bytes 0-1, =1 -> bytes 2-3; SW all.
//  - Load: word sampled on the final ACCESS cycle (so a store immediately preceding is
//    visible); byte/half selected by lane, LB/LH sign-extend, LBU/LHU zero-extend.
//  - rsp_valid de-asserts on the accepting edge; req_valid ignored outside IDLE.
// STRUCTURE
//  - dmem_pkg: funct3 enum (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum
//    (ST_IDLE, ST_ACCESS, ST_RESP), fault-code localparams.
//  - Sub-module dmem_lane_unit (combinational): byte-enable/merge for stores and
//    lane-select/extension for loads; top holds FSM, counter, array, fault checks.
// TESTING
//  - Reset: hold rst_n=0 2 cycles mid-ACCESS of SW -> word unchanged, rsp_valid=0, req_ready=1.
//  - SW 0x8000_00FF @0x4, then LB @0x4 -> 0xFFFF_FFFF; LBU @0x7 -> 0x0000_0080.
//  - SW 0x1122_3344 @0x8; SB 0xAA @0xA; LW @0x8 -> 0x11AA_3344; SH 0xBEEF @0xA -> LW 0xBEEF_3344.
//  - LH @0x6 (mem 0x8000_00FF) -> 0xFFFF_8000; LHU -> 0x0000_8000; LH @0x5 -> rsp_err=1.
//  - Out-of-range SW @DEPTH*4 -> rsp_err=1, all words unchanged; func3=3'b011 load -> rsp_err=1.
//  - READ_LAT=3, rsp_ready low 5 cycles: rsp_valid at E+3, data stable, req_ready=0 till handshake.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory controller.
//  funct3_e : RV32I load/store funct3 encodings
//  state_e  : controller FSM states
//  Fault*   : fault codes, lower value wins when several apply
//  fault_code() : prioritised fault classification of a registered request
package dmem_pkg;

  typedef enum logic [2:0] {
    F3Byte  = 3'b000,
    F3Half  = 3'b001,
    F3Word  = 3'b010,
    F3ByteU = 3'b100,
    F3HalfU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  localparam logic [1:0] FaultNone  = 2'd0;
  localparam logic [1:0] FaultFunc3 = 2'd1;
  localparam logic [1:0] FaultRange = 2'd2;
  localparam logic [1:0] FaultAlign = 2'd3;

  // Priority: illegal funct3, then out-of-range, then misalignment.
  function automatic logic [1:0] fault_code(input logic       we,
                                            input logic [2:0] func3,
                                            input logic       out_of_range,
                                            input logic [1:0] lane);
    logic illegal;
    logic misaligned;
    if (we) illegal = (func3 > 3'b010);
    else    illegal = (func3 inside {3'b011, 3'b110, 3'b111});
    misaligned = ((func3[1:0] == 2'b01) && lane[0]) ||
                 ((func3[1:0] == 2'b10) && (lane != 2'b00));
    if (illegal)           return FaultFunc3;
    else if (out_of_range) return FaultRange;
    else if (misaligned)   return FaultAlign;
    else                   return FaultNone;
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational byte-lane logic for the data-memory controller.
//  func3_i : funct3 of the access (size in [1:0], unsigned flag in [2])
//  lane_i  : byte address bits [1:0]
//  wdata_i : store data, LSBs used for byte/half stores
//  rword_i : current contents of the addressed word
//  wword_o : word after merging the store under its byte enables
//  rdata_o : selected and extended load data
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  logic [3:0]  be;
  logic [31:0] wrep;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store: replicate data across lanes, then keep only enabled bytes.
  always_comb begin
    be   = 4'b1111;
    wrep = wdata_i;
    case (func3_i[1:0])
      2'b00: begin
        be   = 4'b0001 << lane_i;
        wrep = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be   = lane_i[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata_i[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = wdata_i;
      end
    endcase
    wword_o = rword_i;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) wword_o[8*b +: 8] = wrep[8*b +: 8];
    end
  end

  // Load: pick lane, then sign- or zero-extend.
  always_comb begin
    byte_sel = rword_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (func3_i)
      F3Byte:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
      F3ByteU: rdata_o = {24'h0, byte_sel};
      F3Half:  rdata_o = {{16{half_sel[15]}}, half_sel};
      F3HalfU: rdata_o = {16'h0, half_sel};
      default: rdata_o = rword_i;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the RV32I multi-cycle core.
// Word-organised RAM with SB/SH/SW stores and LB/LH/LW/LBU/LHU loads, one outstanding request,
// fixed READ_LAT cycles from accept to response, faults reported with no side effect.
//  clk_i        : clock
//  rst_ni       : synchronous active-low reset (memory contents are kept)
//  req_valid_i  / req_ready_o : request handshake, ready only when idle
//  req_we_i     : 1 = store, 0 = load
//  req_addr_i   : byte address
//  req_wdata_i  : store data
//  req_func3_i  : RV32I funct3
//  rsp_valid_o  / rsp_ready_i : response handshake, response held until accepted
//  rsp_rdata_o  : extended load data, 0 for stores and faults
//  rsp_err_o    : access faulted
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned READ_LAT  = 1,      // 1..4
  parameter logic [31:0] BASE_ADDR = 32'h0   // 4-byte aligned
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_func3_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam logic [31:0] ByteSpan = 32'(Depth * 4);
  localparam logic [1:0]  LatLast  = 2'(READ_LAT - 1);

  state_e      state_q;
  logic [1:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  func3_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem_q [Depth];

  logic [31:0]       offset;
  logic              out_of_range;
  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        fault;
  logic [31:0]       rword;
  logic [31:0]       wword;
  logic [31:0]       load_data;
  logic              commit_store;

  assign offset       = addr_q - BASE_ADDR;
  assign out_of_range = (addr_q < BASE_ADDR) || (offset >= ByteSpan);
  assign word_idx     = offset[ADDR_W+1:2];
  assign fault        = fault_code(we_q, func3_q, out_of_range, addr_q[1:0]);
  assign rword        = mem_q[word_idx];

  // Stores commit on the first ACCESS edge; a reset on that edge drops the write.
  assign commit_store = rst_ni && (state_q == StAccess) && (cnt_q == LatLast) &&
                        we_q && (fault == FaultNone);

  dmem_lane_unit u_lane (
    .func3_i (func3_q),
    .lane_i  (addr_q[1:0]),
    .wdata_i (wdata_q),
    .rword_i (rword),
    .wword_o (wword),
    .rdata_o (load_data)
  );

  always_ff @(posedge clk_i) begin
    if (commit_store) mem_q[word_idx] <= wword;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      func3_q     <= 3'b000;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i && req_ready_q) begin
            we_q        <= req_we_i;
            addr_q      <= req_addr_i;
            wdata_q     <= req_wdata_i;
            func3_q     <= req_func3_i;
            cnt_q       <= LatLast;
            req_ready_q <= 1'b0;
            state_q     <= StAccess;
          end
        end
        StAccess: begin
          if (cnt_q == 2'd0) begin
            // Final ACCESS cycle: the load sees any store already committed.
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= (fault != FaultNone);
            rsp_rdata_q <= ((fault != FaultNone) || we_q) ? 32'h0 : load_data;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: one instance at READ_LAT=1, one at READ_LAT=3.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid1, req_valid3;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_func3;
  logic        rsp_ready1, rsp_ready3;
  logic        req_ready1, req_ready3;
  logic        rsp_valid1, rsp_valid3;
  logic [31:0] rsp_rdata1, rsp_rdata3;
  logic        rsp_err1, rsp_err3;

  logic        sel;
  logic        cur_req_ready, cur_rsp_valid, cur_rsp_err;
  logic [31:0] cur_rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl u_dut1 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid1),
    .req_ready_o (req_ready1),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_func3_i (req_func3),
    .rsp_valid_o (rsp_valid1),
    .rsp_ready_i (rsp_ready1),
    .rsp_rdata_o (rsp_rdata1),
    .rsp_err_o   (rsp_err1)
  );

  dmem_ctrl #(.READ_LAT(3)) u_dut3 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid3),
    .req_ready_o (req_ready3),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_func3_i (req_func3),
    .rsp_valid_o (rsp_valid3),
    .rsp_ready_i (rsp_ready3),
    .rsp_rdata_o (rsp_rdata3),
    .rsp_err_o   (rsp_err3)
  );

  assign cur_req_ready = sel ? req_ready3 : req_ready1;
  assign cur_rsp_valid = sel ? rsp_valid3 : rsp_valid1;
  assign cur_rsp_rdata = sel ? rsp_rdata3 : rsp_rdata1;
  assign cur_rsp_err   = sel ? rsp_err3   : rsp_err1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Full request/response transaction on instance s (0: READ_LAT=1, 1: READ_LAT=3).
  task automatic transact(input logic s, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          input logic [31:0] exp_rdata, input logic exp_err, input string name);
    int lat;
    sel = s;
    @(negedge clk);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_func3 = f3;
    if (s) req_valid3 = 1'b1;
    else   req_valid1 = 1'b1;
    check({name, " req_ready"}, 32'(cur_req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    req_valid3 = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (cur_rsp_valid) break;
    end
    check({name, " latency"}, 32'(lat), s ? 32'd3 : 32'd1);
    check({name, " rdata"}, cur_rsp_rdata, exp_rdata);
    check({name, " err"}, 32'(cur_rsp_err), 32'(exp_err));
    if (s) rsp_ready3 = 1'b1;
    else   rsp_ready1 = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready1 = 1'b0;
    rsp_ready3 = 1'b0;
    check({name, " rsp_valid drop"}, 32'(cur_rsp_valid), 32'd0);
    check({name, " ready again"}, 32'(cur_req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n      = 1'b0;
    req_valid1 = 1'b0;
    req_valid3 = 1'b0;
    rsp_ready1 = 1'b0;
    rsp_ready3 = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_func3  = 3'b000;
    sel        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    check("reset req_ready1", 32'(req_ready1), 32'd1);
    check("reset rsp_valid1", 32'(rsp_valid1), 32'd0);
    check("reset rsp_rdata1", rsp_rdata1, 32'h0);
    check("reset rsp_err1", 32'(rsp_err1), 32'd0);
    check("reset req_ready3", 32'(req_ready3), 32'd1);
    check("reset rsp_valid3", 32'(rsp_valid3), 32'd0);

    // we, addr, wdata, func3, expected rdata, expected err
    vecs.push_back('{1'b1, 32'h04, 32'h8000_00FF, 3'b010, 32'h0,         1'b0}); // SW
    vecs.push_back('{1'b0, 32'h04, 32'h0,         3'b000, 32'hFFFF_FFFF, 1'b0}); // LB
    vecs.push_back('{1'b0, 32'h07, 32'h0,         3'b100, 32'h0000_0080, 1'b0}); // LBU
    vecs.push_back('{1'b0, 32'h06, 32'h0,         3'b001, 32'hFFFF_8000, 1'b0}); // LH
    vecs.push_back('{1'b0, 32'h06, 32'h0,         3'b101, 32'h0000_8000, 1'b0}); // LHU
    vecs.push_back('{1'b0, 32'h05, 32'h0,         3'b001, 32'h0,         1'b1}); // LH misaligned
    vecs.push_back('{1'b1, 32'h08, 32'h1122_3344, 3'b010, 32'h0,         1'b0}); // SW
    vecs.push_back('{1'b1, 32'h0A, 32'h1234_56AA, 3'b000, 32'h0,         1'b0}); // SB lane 2
    vecs.push_back('{1'b0, 32'h08, 32'h0,         3'b010, 32'h11AA_3344, 1'b0}); // LW
    vecs.push_back('{1'b1, 32'h0A, 32'hCAFE_BEEF, 3'b001, 32'h0,         1'b0}); // SH upper
    vecs.push_back('{1'b0, 32'h08, 32'h0,         3'b010, 32'hBEEF_3344, 1'b0}); // LW
    vecs.push_back('{1'b0, 32'h0B, 32'h0,         3'b000, 32'hFFFF_FFBE, 1'b0}); // LB lane 3
    vecs.push_back('{1'b0, 32'h0A, 32'h0,         3'b101, 32'h0000_BEEF, 1'b0}); // LHU upper
    vecs.push_back('{1'b0, 32'h0A, 32'h0,         3'b001, 32'hFFFF_BEEF, 1'b0}); // LH upper
    vecs.push_back('{1'b1, 32'h00, 32'h00C0_FFEE, 3'b010, 32'h0,         1'b0}); // SW word 0
    vecs.push_back('{1'b1, 32'h3C, 32'h5A5A_0001, 3'b010, 32'h0,         1'b0}); // SW last word
    vecs.push_back('{1'b1, 32'h40, 32'hDEAD_DEAD, 3'b010, 32'h0,         1'b1}); // SW out of range
    vecs.push_back('{1'b0, 32'h40, 32'h0,         3'b010, 32'h0,         1'b1}); // LW out of range
    vecs.push_back('{1'b0, 32'h00, 32'h0,         3'b010, 32'h00C0_FFEE, 1'b0}); // no alias write
    vecs.push_back('{1'b0, 32'h3C, 32'h0,         3'b010, 32'h5A5A_0001, 1'b0}); // last word
    vecs.push_back('{1'b0, 32'h08, 32'h0,         3'b011, 32'h0,         1'b1}); // load f3 011
    vecs.push_back('{1'b0, 32'h08, 32'h0,         3'b110, 32'h0,         1'b1}); // load f3 110
    vecs.push_back('{1'b0, 32'h08, 32'h0,         3'b111, 32'h0,         1'b1}); // load f3 111
    vecs.push_back('{1'b1, 32'h08, 32'hDEAD_DEAD, 3'b011, 32'h0,         1'b1}); // store f3 011
    vecs.push_back('{1'b1, 32'h08, 32'hDEAD_DEAD, 3'b100, 32'h0,         1'b1}); // store f3 100
    vecs.push_back('{1'b1, 32'h09, 32'hFFFF_FFFF, 3'b010, 32'h0,         1'b1}); // SW misaligned
    vecs.push_back('{1'b1, 32'h0B, 32'hFFFF_FFFF, 3'b001, 32'h0,         1'b1}); // SH misaligned
    vecs.push_back('{1'b0, 32'h02, 32'h0,         3'b010, 32'h0,         1'b1}); // LW misaligned
    vecs.push_back('{1'b0, 32'h08, 32'h0,         3'b010, 32'hBEEF_3344, 1'b0}); // untouched
    vecs.push_back('{1'b1, 32'h09, 32'h0000_0077, 3'b000, 32'h0,         1'b0}); // SB lane 1
    vecs.push_back('{1'b0, 32'h08, 32'h0,         3'b010, 32'hBEEF_7744, 1'b0}); // LW

    foreach (vecs[i]) begin
      transact(1'b0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3,
               vecs[i].rdata, vecs[i].err, $sformatf("v%0d", i));
    end

    // Reset held two cycles while an SW is in ACCESS: the store must not land.
    sel = 1'b0;
    @(negedge clk);
    req_we     = 1'b1;
    req_addr   = 32'h04;
    req_wdata  = 32'hDEAD_BEEF;
    req_func3  = 3'b010;
    req_valid1 = 1'b1;
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midreset rsp_valid", 32'(rsp_valid1), 32'd0);
    check("midreset req_ready", 32'(req_ready1), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    transact(1'b0, 1'b0, 32'h04, 32'h0, 3'b010, 32'h8000_00FF, 1'b0, "midreset word");

    // READ_LAT=3 instance: store, then a load whose response is held for 5 cycles.
    transact(1'b1, 1'b1, 32'h00, 32'h1234_5678, 3'b010, 32'h0, 1'b0, "lat3 sw");
    sel = 1'b1;
    @(negedge clk);
    req_we     = 1'b0;
    req_addr   = 32'h00;
    req_func3  = 3'b010;
    req_valid3 = 1'b1;
    @(posedge clk);
    #1;
    lat = 0;
    // Keep req_valid high with a different address: must be ignored outside IDLE.
    req_addr = 32'h04;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (rsp_valid3) break;
    end
    check("lat3 hold latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat3 hold valid c%0d", i), 32'(rsp_valid3), 32'd1);
      check($sformatf("lat3 hold rdata c%0d", i), rsp_rdata3, 32'h1234_5678);
      check($sformatf("lat3 hold ready c%0d", i), 32'(req_ready3), 32'd0);
    end
    req_valid3 = 1'b0;
    rsp_ready3 = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready3 = 1'b0;
    check("lat3 hold rsp_valid drop", 32'(rsp_valid3), 32'd0);
    check("lat3 hold ready again", 32'(req_ready3), 32'd1);
    transact(1'b1, 1'b0, 32'h02, 32'h0, 3'b101, 32'h0000_1234, 1'b0, "lat3 lhu");
    transact(1'b1, 1'b0, 32'h01, 32'h0, 3'b100, 32'h0000_0056, 1'b0, "lat3 lbu");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
